key_event_ctrl: RTL and testbench



---
 rtl/key_event_ctrl_if.sv | 11 +
 rtl/key_event_ctrl.sv | 108 ++++++++++
 tb/tb_key_event_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/key_event_ctrl_if.sv
// key_event_ctrl_if: valid/ready event stream carrying {type[1:0], key_id[1:0]}
//   evt_valid : event available on evt_data (producer -> consumer)
//   evt_ready : consumer accepts when evt_valid & evt_ready
//   evt_data  : {type, key_id}; type 01 SHORT, 10 LONG, 11 REPEAT
interface key_event_ctrl_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_data;
  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: classifies four debounced keys into SHORT/LONG/REPEAT events and
// arbitrates them round-robin onto one valid/ready stream.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   key_pulse[k]       : 1-cycle press pulse of key k
//   key_level[k]       : debounced level of key k (0 = pressed)
//   evt                : event stream (master side)
//   key_busy[k]        : key k classifier not idle
//   ovf[k]             : sticky, an event of key k was dropped
//   ovf_clr            : clears all ovf bits (wins over a same-cycle set)
module key_event_ctrl #(
  parameter int CNT_W    = 26,
  parameter int LONG_CYC = 50_000_000,
  parameter int REP_CYC  = 10_000_000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [3:0]             key_pulse,
  input  logic [3:0]             key_level,
  key_event_ctrl_if.master       evt,
  output logic [3:0]             key_busy,
  output logic [3:0]             ovf,
  input  logic                   ovf_clr
);
  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
  localparam logic [1:0] SHORT = 2'b01, LONG = 2'b10, REPEAT = 2'b11;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);
  state_t           state_q [4], state_d [4];
  logic [CNT_W-1:0] cnt_q [4], cnt_d [4];
  logic [1:0]       slot_q [4], slot_d [4];
  logic [1:0]       emit [4];
  logic [3:0]       take, ovf_set, ovf_q, ovf_d, data_q, data_d;
  logic [1:0]       ptr_q, ptr_d, gnt_id;
  logic             valid_q, valid_d, free, gnt;
  always_comb begin
    free = !valid_q || evt.evt_ready;
    gnt = 1'b0;
    gnt_id = ptr_q;
    // search starts one past the last granted key so every key gets a turn
    for (int i = 1; i <= 4; i++)
      if (!gnt && slot_q[ptr_q + 2'(i)] != 2'b00) begin
        gnt = 1'b1;
        gnt_id = ptr_q + 2'(i);
      end
    take = '0;
    ovf_set = '0;
    key_busy = '0;
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k] = cnt_q[k];
      emit[k] = 2'b00;
      key_busy[k] = state_q[k] != IDLE;
      case (state_q[k])
        IDLE:
          if (key_pulse[k]) begin
            state_d[k] = PRESSED;
            cnt_d[k] = '0;
          end
        PRESSED:
          if (key_level[k]) begin
            emit[k] = SHORT;
            state_d[k] = IDLE;
          end else if (cnt_q[k] == LONG_LAST) begin
            emit[k] = LONG;
            state_d[k] = HELD;
            cnt_d[k] = '0;
          end else cnt_d[k] = cnt_q[k] + 1'b1;
        HELD:
          if (key_level[k]) state_d[k] = IDLE;
          else if (cnt_q[k] == REP_LAST) begin
            emit[k] = REPEAT;
            cnt_d[k] = '0;
          end else cnt_d[k] = cnt_q[k] + 1'b1;
        default: state_d[k] = IDLE;
      endcase
      take[k] = free && gnt && gnt_id == 2'(k);
      // a slot being granted this cycle can accept a new event without overflow
      slot_d[k] = (emit[k] != 2'b00 && (slot_q[k] == 2'b00 || take[k])) ? emit[k] :
                  take[k] ? 2'b00 : slot_q[k];
      ovf_set[k] = emit[k] != 2'b00 && slot_q[k] != 2'b00 && !take[k];
    end
    ovf_d = ovf_clr ? '0 : ovf_q | ovf_set;
    valid_d = free ? gnt : valid_q;
    data_d = (free && gnt) ? {slot_q[gnt_id], gnt_id} : data_q;
    ptr_d = (free && gnt) ? gnt_id : ptr_q;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q <= '{default: IDLE};
      cnt_q <= '{default: '0};
      slot_q <= '{default: 2'b00};
      ovf_q <= '0;
      ptr_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      slot_q <= slot_d;
      ovf_q <= ovf_d;
      ptr_q <= ptr_d;
      valid_q <= valid_d;
      data_q <= data_d;
    end
  assign evt.evt_valid = valid_q;
  assign evt.evt_data = data_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: directed and randomized checks of key_event_ctrl against a press-age model
module tb_key_event_ctrl;
  localparam int LC = 8, RC = 4;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0, ovf_clr = 1'b0, ready = 1'b0;
  logic [3:0] key_pulse = '0, key_level = '1, key_busy, ovf;
  key_event_ctrl_if bus ();
  assign bus.evt_ready = ready;
  always #5 sys_clk = ~sys_clk;
  key_event_ctrl #(.CNT_W(26), .LONG_CYC(LC), .REP_CYC(RC)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_pulse(key_pulse), .key_level(key_level),
    .evt(bus), .key_busy(key_busy), .ovf(ovf), .ovf_clr(ovf_clr));
  // model: each key is either inactive or has an age = cycles since its press was taken
  bit         act [4];
  int         age [4];
  logic [1:0] pend [4];
  logic [3:0] m_ovf, m_data;
  logic [1:0] m_ptr;
  logic       m_valid;
  logic [3:0] xfers [$];
  int vectors = 0, miscompares = 0;
  task automatic chk(string n, logic [7:0] a, logic [7:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      act[k] = 0;
      age[k] = 0;
      pend[k] = 2'b00;
    end
    m_ovf = '0;
    m_data = '0;
    m_ptr = '0;
    m_valid = 1'b0;
  endtask
  task automatic model_step();
    logic [1:0] ev [4];
    bit free;
    int g;
    free = !m_valid || ready;
    g = -1;
    if (free)
      for (int i = 1; i <= 4; i++) begin
        int j = (int'(m_ptr) + i) % 4;
        if (g < 0 && pend[j] != 2'b00) g = j;
      end
    for (int k = 0; k < 4; k++) begin
      ev[k] = 2'b00;
      if (act[k]) begin
        age[k]++;
        if (key_level[k]) begin
          if (age[k] <= LC) ev[k] = 2'b01;
          act[k] = 0;
        end else if (age[k] == LC) ev[k] = 2'b10;
        else if (age[k] > LC && (age[k] - LC) % RC == 0) ev[k] = 2'b11;
      end else if (key_pulse[k]) begin
        act[k] = 1;
        age[k] = 0;
      end
    end
    if (free) begin
      m_valid = g >= 0;
      if (g >= 0) begin
        m_data = {pend[g], 2'(g)};
        m_ptr = 2'(g);
      end
    end
    for (int k = 0; k < 4; k++)
      if (ev[k] != 2'b00) begin
        if (pend[k] != 2'b00 && g != k) m_ovf[k] = 1'b1;
        else pend[k] = ev[k];
      end else if (g == k) pend[k] = 2'b00;
    if (ovf_clr) m_ovf = '0;
  endtask
  task automatic compare();
    logic [3:0] b;
    for (int k = 0; k < 4; k++) b[k] = act[k];
    chk("evt_valid", 8'(bus.evt_valid), 8'(m_valid));
    if (m_valid) chk("evt_data", 8'(bus.evt_data), 8'(m_data));
    chk("key_busy", 8'(key_busy), 8'(b));
    chk("ovf", 8'(ovf), 8'(m_ovf));
  endtask
  task automatic cyc();
    if (sys_rst_n && bus.evt_valid && ready) xfers.push_back(bus.evt_data);
    @(posedge sys_clk);
    if (sys_rst_n) model_step();
    else model_reset();
    @(negedge sys_clk);
    compare();
  endtask
  task automatic do_reset();
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    compare();
    cyc();
    sys_rst_n = 1'b1;
  endtask
  task automatic press(int k);
    key_level[k] = 1'b0;
    key_pulse[k] = 1'b1;
    cyc();
    key_pulse[k] = 1'b0;
  endtask
  task automatic check_log(string n, int cnt, logic [15:0] exp);
    chk({n, "_count"}, 8'(xfers.size()), 8'(cnt));
    if (xfers.size() == cnt)
      for (int i = 0; i < cnt; i++) chk({n, "_evt"}, 8'(xfers[i]), 8'(exp[i*4 +: 4]));
    xfers.delete();
  endtask
  initial begin
    model_reset();
    @(negedge sys_clk);
    do_reset();
    chk("rst_valid", 8'(bus.evt_valid), 8'h0);
    chk("rst_data", 8'(bus.evt_data), 8'h0);
    chk("rst_busy", 8'(key_busy), 8'h0);
    chk("rst_ovf", 8'(ovf), 8'h0);
    // short press on key 1
    ready = 1'b1;
    press(1);
    repeat (3) cyc();
    key_level[1] = 1'b1;
    repeat (4) cyc();
    check_log("short", 1, 16'h0005);
    chk("short_ovf", 8'(ovf), 8'h0);
    // long hold on key 2: LONG then three REPEATs
    press(2);
    repeat (20) cyc();
    key_level[2] = 1'b1;
    repeat (4) cyc();
    check_log("hold", 4, 16'hEEEA);
    chk("hold_busy", 8'(key_busy[2]), 8'h0);
    // simultaneous SHORTs on keys 0 and 3 from pointer 0
    do_reset();
    ready = 1'b0;
    key_level[0] = 1'b0;
    key_level[3] = 1'b0;
    key_pulse = 4'b1001;
    cyc();
    key_pulse = '0;
    cyc();
    key_level[0] = 1'b1;
    key_level[3] = 1'b1;
    repeat (2) cyc();
    chk("rr_first", 8'(bus.evt_data), 8'h07);
    ready = 1'b1;
    repeat (3) cyc();
    check_log("rr", 2, 16'h0047);
    // overflow on key 1 while the consumer stalls
    ready = 1'b0;
    repeat (3) begin
      press(1);
      cyc();
      key_level[1] = 1'b1;
      cyc();
    end
    cyc();
    chk("ovf_set", 8'(ovf), 8'h02);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("ovf_clr", 8'(ovf), 8'h00);
    ready = 1'b1;
    repeat (3) cyc();
    check_log("ovf_drain", 2, 16'h0055);
    // release exactly on the LONG threshold cycle
    press(0);
    repeat (LC - 1) cyc();
    key_level[0] = 1'b1;
    repeat (4) cyc();
    check_log("edge", 1, 16'h0004);
    // reset while key 0 is held with an event presented
    ready = 1'b0;
    press(0);
    repeat (LC + 2) cyc();
    chk("pre_rst_valid", 8'(bus.evt_valid), 8'h01);
    chk("pre_rst_data", 8'(bus.evt_data), 8'h08);
    do_reset();
    chk("mid_rst_valid", 8'(bus.evt_valid), 8'h00);
    chk("mid_rst_busy", 8'(key_busy), 8'h00);
    ready = 1'b1;
    repeat (20) cyc();
    key_level[0] = 1'b1;
    cyc();
    check_log("post_rst", 0, 16'h0000);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ready = $urandom_range(0, 3) != 0;
      ovf_clr = $urandom_range(0, 99) == 0;
      for (int k = 0; k < 4; k++) begin
        key_pulse[k] = 1'b0;
        if (key_level[k]) begin
          if ($urandom_range(0, 15) == 0) begin
            key_level[k] = 1'b0;
            key_pulse[k] = 1'b1;
          end
        end else if ($urandom_range(0, 11) == 0) key_level[k] = 1'b1;
        else if ($urandom_range(0, 19) == 0) key_pulse[k] = 1'b1;
      end
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
